// File: rtl/bit_reg_if.sv
// Data/enable bundle for bit_reg: the master drives in/load, the register slave drives out.
interface bit_reg_if #(
  parameter int unsigned WIDTH = 1
);
  logic [WIDTH-1:0] in;
  logic             load;
  logic [WIDTH-1:0] out;

  modport master (
    output in,
    output load,
    input  out
  );

  modport slave (
    input  in,
    input  load,
    output out
  );
endinterface

// File: rtl/bit_reg.sv
// Hack-style "Bit" storage cell with load enable and synchronous active-low clear.
// WIDTH > 1 gives a parallel-load register where all bits share one load.
module bit_reg #(
  parameter int unsigned WIDTH = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  bit_reg_if.slave  bus
);

  logic [WIDTH-1:0] q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (bus.load) begin
      q_d = bus.in;
    end
  end

  // Reset is sampled only on the edge, so it outranks load and never acts between edges.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign bus.out = q_q;

endmodule

// File: tb/tb_bit_reg.sv
// Bench for bit_reg: table-driven vectors on a 1-bit and an 8-bit instance, checked via a
// scoreboard queue, plus hand-written sequences for between-edge behaviour.
module tb_bit_reg;

  typedef struct {
    string      name;
    bit         wide;
    logic [7:0] exp;
  } sb_t;

  typedef struct {
    string      name;
    bit         wide;
    logic       rst;
    logic       ld;
    logic [7:0] din;
    logic [7:0] exp;
  } vec_t;

  logic clk;
  logic rst_n1;
  logic rst_n8;
  int   n_cmp;
  int   n_fail;
  sb_t  sb[$];
  vec_t vecs[$];

  bit_reg_if #(.WIDTH(1)) if1 ();
  bit_reg_if #(.WIDTH(8)) if8 ();

  bit_reg #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n1),
    .bus   (if1)
  );

  bit_reg #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n8),
    .bus   (if8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] cur_out(input bit wide);
    if (wide) return if8.out;
    return {7'b0, if1.out};
  endfunction

  task automatic compare(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_pop(input bit wide);
    sb_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL scoreboard_empty: got no entry, expected one (t=%0t)", $time);
      return;
    end
    e = sb.pop_front();
    compare(e.name, cur_out(wide), e.exp);
  endtask

  // Drive one vector half a cycle ahead of the edge, then compare just after it.
  task automatic step(input vec_t v);
    @(negedge clk);
    if (v.wide) begin
      rst_n8 = v.rst;
      if8.load = v.ld;
      if8.in = v.din;
    end else begin
      rst_n1 = v.rst;
      if1.load = v.ld;
      if1.in = v.din[0];
    end
    sb.push_back('{v.name, v.wide, v.exp});
    @(posedge clk);
    #1;
    check_pop(v.wide);
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst_n1 = 1'b1;
    rst_n8 = 1'b1;
    if1.in = 1'b0;
    if1.load = 1'b0;
    if8.in = 8'h00;
    if8.load = 1'b0;

    //             name            wide rst  ld   din    exp
    vecs.push_back('{"w1_reset",     0, 1'b0, 1'b0, 8'h00, 8'h00});
    vecs.push_back('{"load0",        0, 1'b1, 1'b1, 8'h00, 8'h00});
    vecs.push_back('{"hold0_in1",    0, 1'b1, 1'b0, 8'h01, 8'h00});
    vecs.push_back('{"load1",        0, 1'b1, 1'b1, 8'h01, 8'h01});
    vecs.push_back('{"hold1_in0",    0, 1'b1, 1'b0, 8'h00, 8'h01});
    vecs.push_back('{"hold1_in1",    0, 1'b1, 1'b0, 8'h01, 8'h01});
    vecs.push_back('{"cons_load0",   0, 1'b1, 1'b1, 8'h00, 8'h00});
    vecs.push_back('{"cons_load1",   0, 1'b1, 1'b1, 8'h01, 8'h01});
    vecs.push_back('{"hold1_a",      0, 1'b1, 1'b0, 8'h00, 8'h01});
    vecs.push_back('{"hold1_b",      0, 1'b1, 1'b0, 8'h00, 8'h01});
    vecs.push_back('{"reload0",      0, 1'b1, 1'b1, 8'h00, 8'h00});
    vecs.push_back('{"hold0_b",      0, 1'b1, 1'b0, 8'h01, 8'h00});
    vecs.push_back('{"prio_set1",    0, 1'b1, 1'b1, 8'h01, 8'h01});
    vecs.push_back('{"prio_rst",     0, 1'b0, 1'b1, 8'h01, 8'h00});
    vecs.push_back('{"prio_release", 0, 1'b1, 1'b1, 8'h01, 8'h01});
    vecs.push_back('{"w8_reset",     1, 1'b0, 1'b0, 8'h00, 8'h00});
    vecs.push_back('{"w8_load_a5",   1, 1'b1, 1'b1, 8'hA5, 8'hA5});
    vecs.push_back('{"w8_hold_3c",   1, 1'b1, 1'b0, 8'h3C, 8'hA5});
    vecs.push_back('{"w8_load_5a",   1, 1'b1, 1'b1, 8'h5A, 8'h5A});
    vecs.push_back('{"w8_rst_ld",    1, 1'b0, 1'b1, 8'h3C, 8'h00});
    vecs.push_back('{"w8_load_ff",   1, 1'b1, 1'b1, 8'hFF, 8'hFF});

    foreach (vecs[i]) step(vecs[i]);

    // Reset pulsed low strictly between edges must not touch the stored 1.
    @(negedge clk);
    rst_n1 = 1'b1;
    if1.load = 1'b0;
    if1.in = 1'b0;
    rst_n1 = 1'b0;
    #2;
    compare("rst_pulse_mid", cur_out(0), 8'h01);
    rst_n1 = 1'b1;
    sb.push_back('{"rst_pulse_edge", 0, 8'h01});
    @(posedge clk);
    #1;
    check_pop(0);

    // Reset held across an edge clears only at that edge.
    @(negedge clk);
    rst_n1 = 1'b0;
    #1;
    compare("rst_before_edge", cur_out(0), 8'h01);
    sb.push_back('{"rst_after_edge", 0, 8'h00});
    @(posedge clk);
    #1;
    check_pop(0);

    // load raised and dropped before the edge is never sampled.
    @(negedge clk);
    rst_n1 = 1'b1;
    if1.load = 1'b1;
    if1.in = 1'b1;
    #2;
    if1.load = 1'b0;
    sb.push_back('{"load_glitch", 0, 8'h00});
    @(posedge clk);
    #1;
    check_pop(0);

    // Output keeps the old value during the cycle load is asserted.
    @(negedge clk);
    if1.load = 1'b1;
    if1.in = 1'b1;
    #1;
    compare("pre_edge_hold", cur_out(0), 8'h00);
    sb.push_back('{"post_edge_load", 0, 8'h01});
    @(posedge clk);
    #1;
    check_pop(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
